// File: rtl/des_block_sequencer.sv
// des_block_sequencer: buffers 16-bit host pipe words into 64-bit DES blocks,
// runs each block through the DES core and writes the result back in place.
// The pulse outputs core_start, done and busy all come straight from flops.
// Optional feature: define DES_SEQ_TIMEOUT_EN to enable the core watchdog
// (sets the sticky err flag and abandons the run after TIMEOUT_CYCLES).
module des_block_sequencer #(
    parameter int DEPTH_WORDS    = 256,
    parameter int ADDR_W         = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk1,
    input  logic        reset,
    input  logic        ptr_reset,
    input  logic        start,
    input  logic        decrypt,
    input  logic        pipe_in_write,
    input  logic [15:0] pipe_in_data,
    input  logic        pipe_out_read,
    output logic [15:0] pipe_out_data,
    output logic        core_start,
    output logic        core_decrypt,
    output logic [63:0] core_din,
    input  logic        core_done,
    input  logic [63:0] core_dout,
    output logic        done,
    output logic        busy,
    output logic        err
);

    typedef enum logic [2:0] {
        ST_IDLE, ST_LOAD, ST_ISSUE, ST_WAIT, ST_STORE, ST_NEXT, ST_FIN
    } state_t;

    localparam int WCNT_W = $clog2(TIMEOUT_CYCLES);
`ifdef DES_SEQ_TIMEOUT_EN
    localparam logic TIMEOUT_ON = 1'b1;
`else
    localparam logic TIMEOUT_ON = 1'b0;
`endif
    localparam logic [ADDR_W:0]   WR_ONE   = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0]   WR_DEPTH = (ADDR_W+1)'(DEPTH_WORDS);
    localparam logic [ADDR_W-1:0] RD_ONE   = ADDR_W'(1);
    localparam logic [ADDR_W-2:0] BLK_ONE  = (ADDR_W-1)'(1);
    localparam logic [WCNT_W-1:0] WCNT_ONE = WCNT_W'(1);
    localparam logic [WCNT_W-1:0] WCNT_MAX = WCNT_W'(TIMEOUT_CYCLES - 1);

    logic [15:0] mem [DEPTH_WORDS];

    state_t              state_q, state_d;
    logic [ADDR_W:0]     wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-2:0]   nblk_q, nblk_d;
    logic [ADDR_W-2:0]   blk_q, blk_d;
    logic [1:0]          sub_q, sub_d;
    logic [63:0]         din_q, din_d;
    logic [63:0]         res_q, res_d;
    logic                dec_q, dec_d;
    logic                cstart_q, cstart_d;
    logic                done_q, done_d;
    logic                busy_q, busy_d;
    logic                err_q, err_d;
    logic [WCNT_W-1:0]   wcnt_q, wcnt_d;

    logic                mem_we_s;
    logic [ADDR_W-1:0]   mem_waddr_s;
    logic [15:0]         mem_wdata_s;
    logic [ADDR_W-1:0]   blk_addr_s;
    logic [ADDR_W-2:0]   blk_inc_s;

    // Word address of the current block/word pair and the incremented block index.
    always_comb begin
        blk_addr_s = {blk_q[ADDR_W-3:0], sub_q};
        blk_inc_s  = blk_q + BLK_ONE;
    end

    // Next-state, datapath and single write-port computation.
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        nblk_d      = nblk_q;
        blk_d       = blk_q;
        sub_d       = sub_q;
        din_d       = din_q;
        res_d       = res_q;
        dec_d       = dec_q;
        err_d       = err_q;
        wcnt_d      = wcnt_q;
        mem_we_s    = 1'b0;
        mem_waddr_s = wr_ptr_q[ADDR_W-1:0];
        mem_wdata_s = pipe_in_data;

        case (state_q)
            ST_IDLE: begin
                // Pointer maintenance; a ptr_reset wins over a same-cycle read.
                if (ptr_reset) begin
                    wr_ptr_d = '0;
                    rd_ptr_d = '0;
                end else if (pipe_out_read) begin
                    rd_ptr_d = rd_ptr_q + RD_ONE;
                end else begin
                    rd_ptr_d = rd_ptr_q;
                end
                if (start) begin
                    // Block count uses the pointer as it stood before this cycle.
                    nblk_d  = wr_ptr_q[ADDR_W:2];
                    dec_d   = decrypt;
                    blk_d   = '0;
                    sub_d   = 2'd0;
                    err_d   = 1'b0;
                    // An empty run passes through NEXT so done lands on cycle 2.
                    state_d = (wr_ptr_q[ADDR_W:2] == '0) ? ST_NEXT : ST_LOAD;
                end else if (pipe_in_write) begin
                    if (ptr_reset) begin
                        mem_we_s    = 1'b1;
                        mem_waddr_s = '0;
                        wr_ptr_d    = WR_ONE;
                    end else if (wr_ptr_q < WR_DEPTH) begin
                        mem_we_s    = 1'b1;
                        wr_ptr_d    = wr_ptr_q + WR_ONE;
                    end else begin
                        mem_we_s    = 1'b0;
                    end
                end else begin
                    mem_we_s = 1'b0;
                end
            end
            ST_LOAD: begin
                din_d = {din_q[47:0], mem[blk_addr_s]};
                sub_d = sub_q + 2'd1;
                if (sub_q == 2'd3) begin
                    state_d = ST_ISSUE;
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_ISSUE: begin
                wcnt_d  = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                wcnt_d = wcnt_q + WCNT_ONE;
                if (core_done) begin
                    res_d   = core_dout;
                    state_d = ST_STORE;
                end else if (TIMEOUT_ON && (wcnt_q == WCNT_MAX)) begin
                    err_d   = 1'b1;
                    state_d = ST_FIN;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_STORE: begin
                mem_we_s    = 1'b1;
                mem_waddr_s = blk_addr_s;
                mem_wdata_s = res_q[63:48];
                res_d       = {res_q[47:0], 16'h0000};
                sub_d       = sub_q + 2'd1;
                if (sub_q == 2'd3) begin
                    state_d = ST_NEXT;
                end else begin
                    state_d = ST_STORE;
                end
            end
            ST_NEXT: begin
                blk_d = blk_inc_s;
                sub_d = 2'd0;
                if ((nblk_q == '0) || (blk_inc_s == nblk_q)) begin
                    state_d = ST_FIN;
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Pulse/level outputs are decoded from the next state so they leave flops.
        cstart_d = (state_d == ST_ISSUE);
        done_d   = (state_d == ST_FIN);
        busy_d   = (state_d != ST_IDLE);
    end

    // Sequencer state and output registers.
    always_ff @(posedge clk1 or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            nblk_q   <= '0;
            blk_q    <= '0;
            sub_q    <= 2'd0;
            din_q    <= 64'h0;
            res_q    <= 64'h0;
            dec_q    <= 1'b0;
            cstart_q <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
            wcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            nblk_q   <= nblk_d;
            blk_q    <= blk_d;
            sub_q    <= sub_d;
            din_q    <= din_d;
            res_q    <= res_d;
            dec_q    <= dec_d;
            cstart_q <= cstart_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            err_q    <= err_d;
            wcnt_q   <= wcnt_d;
        end
    end

    // Word buffer; contents intentionally survive reset.
    always_ff @(posedge clk1) begin
        if (mem_we_s) begin
            mem[mem_waddr_s] <= mem_wdata_s;
        end
    end

    assign pipe_out_data = (busy_q || reset) ? 16'h0000 : mem[rd_ptr_q];
    assign core_start    = cstart_q;
    assign core_decrypt  = dec_q;
    assign core_din      = din_q;
    assign done          = done_q;
    assign busy          = busy_q;
    assign err           = err_q;

endmodule

// File: tb/tb_des_block_sequencer.sv
// Directed bench for des_block_sequencer with an XOR core stub (latency 16).
module tb_des_block_sequencer;

    localparam logic [63:0] MASK = 64'hFFFF_0000_FFFF_0000;

    logic        clk1 = 1'b0;
    logic        reset = 1'b1;
    logic        ptr_reset = 1'b0;
    logic        start = 1'b0;
    logic        decrypt = 1'b0;
    logic        pipe_in_write = 1'b0;
    logic [15:0] pipe_in_data = 16'h0000;
    logic        pipe_out_read = 1'b0;
    logic [15:0] pipe_out_data;
    logic        core_start;
    logic        core_decrypt;
    logic [63:0] core_din;
    logic        core_done;
    logic [63:0] core_dout;
    logic        done;
    logic        busy;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;

    int          done_cyc;
    int          n_cs;
    logic [63:0] first_din;
    logic        dec_seen;
    logic        pod_bad;

    logic [15:0] pend = 16'h0000;
    logic [63:0] stub_res = 64'h0;
    logic        stub_mute = 1'b0;

    always #5 clk1 = ~clk1;

    des_block_sequencer dut (
        .clk1          (clk1),
        .reset         (reset),
        .ptr_reset     (ptr_reset),
        .start         (start),
        .decrypt       (decrypt),
        .pipe_in_write (pipe_in_write),
        .pipe_in_data  (pipe_in_data),
        .pipe_out_read (pipe_out_read),
        .pipe_out_data (pipe_out_data),
        .core_start    (core_start),
        .core_decrypt  (core_decrypt),
        .core_din      (core_din),
        .core_done     (core_done),
        .core_dout     (core_dout),
        .done          (done),
        .busy          (busy),
        .err           (err)
    );

    // Core stub: result is din ^ MASK, done 16 cycles after core_start.
    always @(posedge clk1) begin
        pend <= {pend[14:0], core_start & ~stub_mute};
        if (core_start) stub_res <= core_din ^ MASK;
    end
    assign core_done = pend[15];
    assign core_dout = pend[15] ? stub_res : 64'h0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk1);
        #1;
    endtask

    task automatic wr(input logic [15:0] d);
        pipe_in_write = 1'b1;
        pipe_in_data  = d;
        tick();
        pipe_in_write = 1'b0;
    endtask

    task automatic ptr_clr;
        ptr_reset = 1'b1;
        tick();
        ptr_reset = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [15:0] exp);
        chk(tag, {48'h0, pipe_out_data}, {48'h0, exp});
        pipe_out_read = 1'b1;
        tick();
        pipe_out_read = 1'b0;
    endtask

    // Pulse start (cycle 0), then watch cycles 1..budget for done.
    // Cycle 3 injects host traffic that must be ignored while busy.
    task run(input int budget);
        done_cyc = -1;
        n_cs     = 0;
        first_din = 64'h0;
        dec_seen = 1'b0;
        pod_bad  = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int cyc = 1; cyc <= budget; cyc++) begin
            if (cyc == 1) chk("busy_rise", {63'h0, busy}, 64'h1);
            if (core_start) begin
                if (n_cs == 0) first_din = core_din;
                dec_seen = core_decrypt;
                n_cs++;
            end
            if (busy && (pipe_out_data !== 16'h0000)) pod_bad = 1'b1;
            if (done) begin
                done_cyc = cyc;
                chk("busy_at_done", {63'h0, busy}, 64'h1);
                break;
            end
            if (cyc == 3) begin
                pipe_in_write = 1'b1;
                pipe_in_data  = 16'hDEAD;
                start         = 1'b1;
                ptr_reset     = 1'b1;
                pipe_out_read = 1'b1;
                tick();
                pipe_in_write = 1'b0;
                start         = 1'b0;
                ptr_reset     = 1'b0;
                pipe_out_read = 1'b0;
            end else begin
                tick();
            end
        end
        tick();
        chk("busy_fall", {63'h0, busy}, 64'h0);
        chk("done_single", {63'h0, done}, 64'h0);
        chk("pipe_out_zero_busy", {63'h0, pod_bad}, 64'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] v;
        logic [15:0] e;

        // Reset state
        tick(); tick();
        chk("rst_busy", {63'h0, busy}, 64'h0);
        chk("rst_done", {63'h0, done}, 64'h0);
        chk("rst_core_start", {63'h0, core_start}, 64'h0);
        chk("rst_err", {63'h0, err}, 64'h0);
        chk("rst_core_din", core_din, 64'h0);
        chk("rst_pipe_out", {48'h0, pipe_out_data}, 64'h0);
        reset = 1'b0;
        tick();

        // Two blocks, decrypt; ptr_reset together with the first write
        decrypt = 1'b1;
        wr(16'h5555);
        wr(16'h5555);
        ptr_reset = 1'b1;
        wr(16'h0001);
        ptr_reset = 1'b0;
        for (int i = 2; i <= 8; i++) wr(16'(i));
        run(200);
        chk("two_done_cycle", 64'(done_cyc), 64'd53);
        chk("two_core_starts", 64'(n_cs), 64'd2);
        chk("two_first_din", first_din, 64'h0001_0002_0003_0004);
        chk("two_decrypt", {63'h0, dec_seen}, 64'h1);
        rd_chk("two_rd0", 16'hFFFE);
        rd_chk("two_rd1", 16'h0002);
        rd_chk("two_rd2", 16'hFFFC);
        rd_chk("two_rd3", 16'h0004);
        rd_chk("two_rd4", 16'hFFFA);
        rd_chk("two_rd5", 16'h0006);
        rd_chk("two_rd6", 16'hFFF8);
        rd_chk("two_rd7", 16'h0008);

        // Partial block, encrypt: words 4-5 untouched, busy write dropped
        decrypt = 1'b0;
        ptr_clr();
        for (int i = 0; i < 6; i++) wr(16'h0011 + 16'(i));
        run(200);
        chk("part_done_cycle", 64'(done_cyc), 64'd27);
        chk("part_core_starts", 64'(n_cs), 64'd1);
        chk("part_first_din", first_din, 64'h0011_0012_0013_0014);
        chk("part_decrypt", {63'h0, dec_seen}, 64'h0);
        ptr_clr();
        rd_chk("part_rd0", 16'hFFEE);
        rd_chk("part_rd1", 16'h0012);
        rd_chk("part_rd2", 16'hFFEC);
        rd_chk("part_rd3", 16'h0014);
        rd_chk("part_rd4", 16'h0015);
        rd_chk("part_rd5", 16'h0016);
        rd_chk("part_rd6_busy_write_dropped", 16'hFFF8);

        // Empty buffer
        ptr_clr();
        run(50);
        chk("empty_done_cycle", 64'(done_cyc), 64'd2);
        chk("empty_core_starts", 64'(n_cs), 64'd0);

        // Full buffer: 260 writes, last 4 dropped; busy-time traffic ignored
        ptr_clr();
        for (int i = 0; i < 260; i++) wr(16'h0100 + 16'(i));
        run(2000);
        chk("full_done_cycle", 64'(done_cyc), 64'd1665);
        chk("full_core_starts", 64'(n_cs), 64'd64);
        chk("full_first_din", first_din, 64'h0100_0101_0102_0103);
        wr(16'hBEEF);
        for (int i = 0; i < 256; i++) begin
            v = 16'h0100 + 16'(i);
            e = ((i % 4) == 0 || (i % 4) == 2) ? ~v : v;
            rd_chk("full_rd", e);
        end
        rd_chk("full_rd_wrap", 16'hFEFF);

        // Mid-operation reset during WAIT of block 0
        ptr_clr();
        for (int i = 0; i < 4; i++) wr(16'h0A01 + 16'(i));
        decrypt = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        chk("mid_busy_in_wait", {63'h0, busy}, 64'h1);
        reset = 1'b1;
        tick();
        chk("mid_busy", {63'h0, busy}, 64'h0);
        chk("mid_core_start", {63'h0, core_start}, 64'h0);
        chk("mid_done", {63'h0, done}, 64'h0);
        chk("mid_core_decrypt", {63'h0, core_decrypt}, 64'h0);
        reset = 1'b0;
        tick();
        chk("mid_buffer_kept", {48'h0, pipe_out_data}, 64'h0A01);
        run(50);
        chk("mid_idle_empty_done", 64'(done_cyc), 64'd2);
        chk("mid_idle_no_core_start", 64'(n_cs), 64'd0);
        repeat (20) tick();

`ifdef DES_SEQ_TIMEOUT_EN
        // Watchdog: core never answers
        stub_mute = 1'b1;
        ptr_clr();
        for (int i = 0; i < 4; i++) wr(16'h0C01 + 16'(i));
        run(1200);
        chk("to_done_cycle", 64'(done_cyc), 64'd1030);
        chk("to_err_set", {63'h0, err}, 64'h1);
        chk("to_store_skipped", {48'h0, pipe_out_data}, 64'h0C01);
        stub_mute = 1'b0;
        ptr_clr();
        run(50);
        chk("to_err_cleared", {63'h0, err}, 64'h0);
`else
        chk("err_tied_low", {63'h0, err}, 64'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
